// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_v2 family.
package fifo_pkg;

    localparam int DEF_W = 8;
    localparam int DEF_N = 4;

    localparam int FWFT_REG  = 0;
    localparam int FWFT_FALL = 1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// D x W storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int D  = 1 << DEF_N,
    parameter int AW = clog2(D)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd,
    input  logic [AW-1:0] ra,
    output logic [W-1:0]  rd
);

    logic [W-1:0] mem [D];

    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
    end

    assign rd = mem[ra];

endmodule

// File: rtl/fifo_v2.sv
// Synchronous FIFO: pointers, occupancy counter, status/error flags and
// either a registered read port or first-word-fall-through output.
module fifo_v2
    import fifo_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int N    = DEF_N,
    parameter int AF   = (1 << N) - 1,
    parameter int AE   = 1,
    parameter int FWFT = FWFT_REG
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         we,
    input  logic [W-1:0] wd,
    input  logic         re,
    output logic [W-1:0] rd,
    output logic         rv,
    output logic         full,
    output logic         empty,
    output logic         afull,
    output logic         aempty,
    output logic [N:0]   level,
    output logic         ovf,
    output logic         udf
);

    localparam int         D      = 1 << N;
    localparam logic [N:0] LVL_D  = (N + 1)'(D);
    localparam logic [N:0] LVL_AF = (N + 1)'(AF);
    localparam logic [N:0] LVL_AE = (N + 1)'(AE);

    logic [N-1:0] wptr;
    logic [N-1:0] rptr;
    logic         wr_ok;
    logic         rd_ok;
    logic [W-1:0] head;

    assign full   = (level == LVL_D);
    assign empty  = (level == '0);
    assign afull  = (level >= LVL_AF);
    assign aempty = (level <= LVL_AE);

    // full/empty gate acceptance, so simultaneous re&we on a full FIFO only
    // reads and on an empty FIFO only writes
    assign wr_ok = we && !full && !clr;
    assign rd_ok = re && !empty && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (wr_ok)
                wptr <= wptr + 1'b1;
            if (rd_ok)
                rptr <= rptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (we && full)
                ovf <= 1'b1;
            if (re && empty)
                udf <= 1'b1;
        end
    end

    fifo_ram #(
        .W (W),
        .D (D)
    ) u_ram (
        .clk (clk),
        .we  (wr_ok),
        .wa  (wptr),
        .wd  (wd),
        .ra  (rptr),
        .rd  (head)
    );

    if (FWFT == FWFT_REG) begin : g_reg
        logic [W-1:0] rd_q;
        logic         rv_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
                rv_q <= 1'b0;
            end else begin
                rv_q <= rd_ok;
                if (rd_ok)
                    rd_q <= head;
            end
        end

        assign rd = rd_q;
        assign rv = rv_q;
    end else begin : g_fwft
        assign rd = head;
        assign rv = !empty;
    end

endmodule

// File: tb/tb_fifo_v2.sv
// Directed scoreboard bench: registered-read instance (a) and FWFT instance (b).
module tb_fifo_v2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       clr_a = 1'b0, we_a = 1'b0, re_a = 1'b0;
    logic [3:0] wd_a = '0, rd_a;
    logic       rv_a, full_a, empty_a, afull_a, aempty_a, ovf_a, udf_a;
    logic [2:0] level_a;

    logic       clr_b = 1'b0, we_b = 1'b0, re_b = 1'b0;
    logic [3:0] wd_b = '0, rd_b;
    logic       rv_b, full_b, empty_b, afull_b, aempty_b, ovf_b, udf_b;
    logic [2:0] level_b;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] qa[$];
    logic [3:0] qb[$];

    always #5 clk = ~clk;

    fifo_v2 #(.W(4), .N(2), .AF(3), .AE(1), .FWFT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr_a), .we(we_a), .wd(wd_a), .re(re_a),
        .rd(rd_a), .rv(rv_a), .full(full_a), .empty(empty_a), .afull(afull_a),
        .aempty(aempty_a), .level(level_a), .ovf(ovf_a), .udf(udf_a)
    );

    fifo_v2 #(.W(4), .N(2), .AF(3), .AE(1), .FWFT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr_b), .we(we_b), .wd(wd_b), .re(re_b),
        .rd(rd_b), .rv(rv_b), .full(full_b), .empty(empty_b), .afull(afull_b),
        .aempty(aempty_b), .level(level_b), .ovf(ovf_b), .udf(udf_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents read data.
    always @(negedge clk) begin
        if (rv_a) begin
            if (qa.size() == 0)
                chk("a unexpected rv", 32'(rv_a), 32'd0);
            else
                chk("a rd", 32'(rd_a), 32'(qa.pop_front()));
        end
        if (re_b && !empty_b) begin
            if (qb.size() == 0)
                chk("b unexpected pop", 32'(re_b), 32'd0);
            else
                chk("b rd", 32'(rd_b), 32'(qb.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst level", 32'(level_a), 32'd0);
        chk("rst empty", 32'(empty_a), 32'd1);
        chk("rst full", 32'(full_a), 32'd0);
        chk("rst aempty", 32'(aempty_a), 32'd1);
        chk("rst afull", 32'(afull_a), 32'd0);
        chk("rst ovf", 32'(ovf_a), 32'd0);
        chk("rst udf", 32'(udf_a), 32'd0);
        chk("rst rv", 32'(rv_a), 32'd0);
        chk("rst rd", 32'(rd_a), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // fill 0..3, rising pass of afull/aempty
        for (int i = 0; i < 4; i++) begin
            we_a = 1'b1;
            wd_a = 4'(i);
            tick();
            chk("fill level", 32'(level_a), 32'(i + 1));
            chk("fill afull", 32'(afull_a), 32'((i + 1) >= 3));
            chk("fill aempty", 32'(aempty_a), 32'((i + 1) <= 1));
        end
        we_a = 1'b0;
        chk("full after 4", 32'(full_a), 32'd1);

        // drain, falling pass
        for (int i = 0; i < 4; i++) begin
            re_a = 1'b1;
            qa.push_back(4'(i));
            tick();
            chk("drain level", 32'(level_a), 32'(3 - i));
            chk("drain afull", 32'(afull_a), 32'((3 - i) >= 3));
            chk("drain aempty", 32'(aempty_a), 32'((3 - i) <= 1));
        end
        re_a = 1'b0;
        tick();
        chk("empty after drain", 32'(empty_a), 32'd1);
        chk("rv low after drain", 32'(rv_a), 32'd0);

        // refill across the pointer wrap, then overflow
        for (int i = 0; i < 4; i++) begin
            we_a = 1'b1;
            wd_a = 4'(i);
            tick();
        end
        wd_a = 4'hF;
        tick();
        we_a = 1'b0;
        chk("ovf set", 32'(ovf_a), 32'd1);
        chk("ovf level", 32'(level_a), 32'd4);
        tick();
        chk("ovf sticky", 32'(ovf_a), 32'd1);

        // re&we while full: read wins, head is still 0
        we_a = 1'b1;
        wd_a = 4'h7;
        re_a = 1'b1;
        qa.push_back(4'h0);
        tick();
        we_a = 1'b0;
        re_a = 1'b0;
        chk("full re&we level", 32'(level_a), 32'd3);

        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("clr level", 32'(level_a), 32'd0);
        chk("clr empty", 32'(empty_a), 32'd1);
        chk("clr ovf", 32'(ovf_a), 32'd0);
        chk("clr rv", 32'(rv_a), 32'd0);

        // re&we while empty: write wins, udf set
        we_a = 1'b1;
        re_a = 1'b1;
        wd_a = 4'h5;
        tick();
        we_a = 1'b0;
        re_a = 1'b0;
        chk("udf set", 32'(udf_a), 32'd1);
        chk("udf level", 32'(level_a), 32'd1);
        chk("udf no rv", 32'(rv_a), 32'd0);
        re_a = 1'b1;
        qa.push_back(4'h5);
        tick();
        re_a = 1'b0;
        tick();
        chk("udf sticky", 32'(udf_a), 32'd1);
        chk("empty after 5", 32'(empty_a), 32'd1);

        // mid-burst asynchronous reset
        we_a = 1'b1;
        wd_a = 4'h9;
        tick();
        wd_a = 4'hA;
        tick();
        we_a = 1'b0;
        re_a = 1'b1;
        tick();
        re_a = 1'b0;
        chk("pre-rst rv", 32'(rv_a), 32'd1);
        chk("pre-rst rd", 32'(rd_a), 32'h9);
        #1 rst_n = 1'b0;
        #1;
        chk("arst rv", 32'(rv_a), 32'd0);
        chk("arst rd", 32'(rd_a), 32'd0);
        chk("arst level", 32'(level_a), 32'd0);
        chk("arst empty", 32'(empty_a), 32'd1);
        chk("arst aempty", 32'(aempty_a), 32'd1);
        chk("arst udf", 32'(udf_a), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        we_a = 1'b1;
        wd_a = 4'hC;
        tick();
        we_a = 1'b0;
        chk("post-rst level", 32'(level_a), 32'd1);
        re_a = 1'b1;
        qa.push_back(4'hC);
        tick();
        re_a = 1'b0;
        tick();
        chk("post-rst empty", 32'(empty_a), 32'd1);

        // FWFT instance
        we_b = 1'b1;
        wd_b = 4'hA;
        tick();
        we_b = 1'b0;
        chk("fwft empty", 32'(empty_b), 32'd0);
        chk("fwft rd", 32'(rd_b), 32'hA);
        chk("fwft rv", 32'(rv_b), 32'd1);
        tick();
        chk("fwft rd hold", 32'(rd_b), 32'hA);
        re_b = 1'b1;
        qb.push_back(4'hA);
        tick();
        re_b = 1'b0;
        chk("fwft popped", 32'(empty_b), 32'd1);
        chk("fwft rv empty", 32'(rv_b), 32'd0);

        for (int i = 0; i < 10; i++) begin
            we_b = 1'b1;
            wd_b = 4'(i);
            re_b = (i > 0);
            if (i > 0)
                qb.push_back(4'(i - 1));
            tick();
            chk("fwft wrap level", 32'(level_b), 32'd1);
        end
        we_b = 1'b0;
        re_b = 1'b1;
        qb.push_back(4'h9);
        tick();
        re_b = 1'b0;
        tick();
        chk("fwft final empty", 32'(empty_b), 32'd1);
        chk("fwft no udf", 32'(udf_b), 32'd0);

        chk("a queue drained", 32'(qa.size()), 32'd0);
        chk("b queue drained", 32'(qb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_v2.md
FIFO_V2 -- requirements
Module: fifo_v2

Interface
REQ-001 Parameter W, default 8: data width in bits, W >= 1.
REQ-002 Parameter N, default 4: address width; depth D = 2^N entries, N >= 1.
REQ-003 Parameter AF, default D-1: almost-full threshold, 1..D.
REQ-004 Parameter AE, default 1: almost-empty threshold, 0..D-1.
REQ-005 Parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-008 clr  in  1  synchronous flush.
REQ-009 we  in  1  write request.
REQ-010 wd  in  W  write data.
REQ-011 re  in  1  read request (pop).
REQ-012 rd  out  W  read data.
REQ-013 rv  out  1  rd valid strobe (FWFT=0 only; tied to !empty when FWFT=1).
REQ-014 full, empty, afull, aempty  out  1 each  status flags.
REQ-015 level  out  N+1  current occupancy, 0..D.
REQ-016 ovf, udf  out  1 each  sticky overflow/underflow error flags.

Function
REQ-017 Write is accepted iff we && !full && !clr; wd is stored at the write pointer and the write pointer increments modulo D.
REQ-018 Read is accepted iff re && !empty && !clr; the read pointer increments modulo D.
REQ-019 Per-cycle level update: +1 on write only, -1 on read only, unchanged on both or neither; no other update path except clr/reset.
REQ-020 Simultaneous re&we when full: read accepted, write rejected (ovf set); level becomes D-1.
REQ-021 Simultaneous re&we when empty: write accepted, read rejected (udf set); level becomes 1.
REQ-022 full = (level == D); empty = (level == 0); afull = (level >= AF); aempty = (level <= AE); all derived from the registered level, valid the cycle after the causing edge.
REQ-023 ovf sets on any cycle with we && full && !clr, and stays set until clr or reset.
REQ-024 udf sets on any cycle with re && empty && !clr, and stays set until clr or reset.
REQ-025 FWFT=0: on an accepted read, rd is registered with the head entry and rv pulses high for exactly one cycle after the edge; otherwise rd holds its last value and rv = 0.
REQ-026 FWFT=1: rd continuously presents the head entry whenever !empty; rd is don't-care when empty; re pops it.
REQ-027 Pointer wrap-around is seamless: data order is preserved across any number of wraps.
REQ-028 clr (priority over we/re): pointers and level go to 0; ovf and udf go to 0; rv goes to 0; memory contents are not cleared.

Reset
REQ-029 While rst_n = 0: pointers = 0, level = 0, empty = 1, full = 0, aempty = 1, afull = 0 (AF >= 1), ovf = udf = 0, rv = 0, rd = 0.
REQ-030 Reset asserted mid-operation discards all contents immediately; the first operation after deassertion sees an empty FIFO.
REQ-031 Memory array is not reset.

Structure
REQ-032 Shared package fifo_pkg holds the clog2 function, the default W/N constants and the FWFT mode constants.
REQ-033 Storage is a separate sub-module fifo_ram: D x W, one write port, one asynchronous read port, no reset.
REQ-034 fifo_v2 contains the pointers, level counter, flag logic and the FWFT=0 output register.

Verification
REQ-035 W=4, N=2, FWFT=0: write 0,1,2,3 -> full=1 and level=4; then 4 reads -> rd sequence 0,1,2,3, each with rv=1 one cycle after re; empty=1 at the end.
REQ-036 Full FIFO, we=1 with wd=F and re=0 -> write dropped, ovf=1 and sticky; a later read returns the original head, 0.
REQ-037 Empty FIFO, re=1 and we=1 with wd=5 -> udf=1 and level=1; the next read returns 5.
REQ-038 FWFT=1: write A -> rd=A while empty=0 with no re; re pops it; 10 writes/reads interleaved across a wrap return data in order.
REQ-039 AF=3, AE=1: fill 0 -> 4 -> 0 -> afull asserts at level 3 and aempty asserts at level <= 1, on both the rising and falling passes.
REQ-040 clr with level=3 and ovf=1 -> next cycle level=0, empty=1, ovf=0; rst_n pulsed low mid-burst -> outputs take their REQ-029 values asynchronously.
